// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for CPU loads/stores.
// Serves one request at a time over a req/ready handshake. Each access is
// delayed by WAIT_CYC wait states; word and byte (lb/sb) accesses are supported
// on a little-endian 2^ADDR_W byte store.
//
// Params : WAIT_CYC (0..15) wait states per access, ADDR_W byte-address width
// Ports  : i_clk, i_rst (async, active low)
//          i_req, i_we (1=store), i_byte_en (1=byte), i_addr, i_wdata
//          o_rdata (held until next response), o_ready (1-cycle pulse),
//          o_err (misaligned word, valid with ready), o_busy (in wait states)
// Macro  : DMEM_LB_SIGNEXT_EN -- byte loads sign-extend (lb); otherwise
//          zero-extend (lbu).
module dmem_responder #(
  parameter int WAIT_CYC = 1,
  parameter int ADDR_W   = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic              i_byte_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_ready,
  output logic              o_err,
  output logic              o_busy
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // State entered from an accepting cycle.
  localparam state_t ACC_ST = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
  localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_we, r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [WORDS];

  logic              w_accept, w_do_acc;
  logic              w_we, w_be, w_mis, w_wr_en;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata, w_word, w_ld, w_wr_word;
  logic [7:0]        w_byte;

  assign w_accept = i_req && (r_state == S_IDLE || r_state == S_RESP);

  // With no wait states the access happens on the accepting edge itself, so
  // it must use the live inputs; otherwise it uses the captured request.
  always_comb begin
    if (WAIT_CYC == 0) begin
      w_do_acc = w_accept;
      w_we     = i_we;
      w_be     = i_byte_en;
      w_addr   = i_addr;
      w_wdata  = i_wdata;
    end else begin
      w_do_acc = (r_state == S_WAIT) && (r_cnt == 4'd0);
      w_we     = r_we;
      w_be     = r_be;
      w_addr   = r_addr;
      w_wdata  = r_wdata;
    end
  end

  always_comb begin
    w_word    = r_mem[w_addr[ADDR_W-1:2]];
    w_byte    = w_word[{w_addr[1:0], 3'b000} +: 8];
    w_mis     = !w_be && (w_addr[1:0] != 2'b00);
    w_wr_en   = w_do_acc && w_we && !w_mis;
    w_wr_word = w_be ? w_word : w_wdata;
    if (w_be) w_wr_word[{w_addr[1:0], 3'b000} +: 8] = w_wdata[7:0];
    w_ld = 32'd0;
    if (!w_mis && !w_we) begin
      if (w_be) begin
`ifdef DMEM_LB_SIGNEXT_EN
        w_ld = {{24{w_byte[7]}}, w_byte};
`else
        w_ld = {24'd0, w_byte};
`endif
      end else begin
        w_ld = w_word;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_req) w_next = ACC_ST;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = i_req ? ACC_ST : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_be    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= i_we;
        r_be    <= i_byte_en;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_cnt   <= CNT_INIT;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_do_acc) begin
        r_rdata <= w_ld;
        r_err   <= w_mis;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[w_addr[ADDR_W-1:2]] <= w_wr_word;
  end

  assign o_ready = (r_state == S_RESP);
  assign o_busy  = (r_state == S_WAIT);
  assign o_err   = r_err && o_ready;
  assign o_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic             clk;
  logic             rst;
  logic [2:0]       req, we, be;
  logic [2:0][9:0]  addr;
  logic [2:0][31:0] wdata;
  logic [2:0][31:0] rdata;
  logic [2:0]       ready, err, busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference memory image per instance, word-addressed.
  logic [31:0] mdl [3][256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYC(0), .ADDR_W(10)) u_w0 (
    .i_clk(clk), .i_rst(rst), .i_req(req[0]), .i_we(we[0]), .i_byte_en(be[0]),
    .i_addr(addr[0]), .i_wdata(wdata[0]), .o_rdata(rdata[0]), .o_ready(ready[0]),
    .o_err(err[0]), .o_busy(busy[0]));
  dmem_responder #(.WAIT_CYC(1), .ADDR_W(10)) u_w1 (
    .i_clk(clk), .i_rst(rst), .i_req(req[1]), .i_we(we[1]), .i_byte_en(be[1]),
    .i_addr(addr[1]), .i_wdata(wdata[1]), .o_rdata(rdata[1]), .o_ready(ready[1]),
    .o_err(err[1]), .o_busy(busy[1]));
  dmem_responder #(.WAIT_CYC(3), .ADDR_W(10)) u_w3 (
    .i_clk(clk), .i_rst(rst), .i_req(req[2]), .i_we(we[2]), .i_byte_en(be[2]),
    .i_addr(addr[2]), .i_wdata(wdata[2]), .o_rdata(rdata[2]), .o_ready(ready[2]),
    .o_err(err[2]), .o_busy(busy[2]));

  function automatic int wc(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural memory: applies one access and returns the expected response.
  task automatic model_txn(input int d, input bit w, input bit b, input logic [9:0] a,
                           input logic [31:0] wd, output logic [31:0] erd, output logic eerr);
    int idx, lane;
    logic [31:0] word, bb;
    idx  = int'(a[9:2]);
    lane = int'(a[1:0]);
    erd  = 32'd0;
    eerr = 1'b0;
    if (!b && lane != 0) begin
      eerr = 1'b1;
    end else if (w) begin
      if (b) begin
        word = mdl[d][idx];
        word[lane*8 +: 8] = wd[7:0];
        mdl[d][idx] = word;
      end else begin
        mdl[d][idx] = wd;
      end
    end else if (b) begin
      bb = (mdl[d][idx] >> (8 * lane)) & 32'hFF;
      erd = bb;
`ifdef DMEM_LB_SIGNEXT_EN
      if (bb >= 32'd128) erd = bb | 32'hFFFF_FF00;
`endif
    end else begin
      erd = mdl[d][idx];
    end
  endtask

  // One isolated transaction; checks latency, busy, err and (for loads) rdata.
  task automatic txn(input int d, input bit w, input bit b, input logic [9:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int k;
    logic [31:0] erd;
    logic eerr;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    @(negedge clk);
    req[d] = 1'b0;
    k = 1;
    if (wc(d) > 0) begin
      chk("busy_wait", 32'(busy[d]), 32'd1);
      chk("err_wait", 32'(err[d]), 32'd0);
    end
    while (!ready[d] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, wc(d) + 1);
    rd = rdata[d];
    er = err[d];
    model_txn(d, w, b, a, wd, erd, eerr);
    chk("err", 32'(er), 32'(eerr));
    if (!w || eerr) chk("rdata", rd, erd);
  endtask

  // Four loads with req held high; ready spacing must be WAIT_CYC+1.
  task automatic b2b(input int d, input logic [9:0] base);
    int k;
    logic [31:0] erd;
    logic eerr;
    @(negedge clk);
    req[d] = 1'b1; we[d] = 1'b0; be[d] = 1'b0; addr[d] = base;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      k = 1;
      while (!ready[d] && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("b2b_gap", k, wc(d) + 1);
      model_txn(d, 1'b0, 1'b0, base + 10'(4 * i), 32'd0, erd, eerr);
      chk("b2b_rdata", rdata[d], erd);
      if (i < 3) addr[d] = base + 10'(4 * (i + 1));
      else req[d] = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    rst = 1'b1; req = '0; we = '0; be = '0; addr = '0; wdata = '0;

    // Reset asserted between edges: outputs clear without a clock edge.
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", 32'(ready[d]), 32'd0);
      chk("rst_err", 32'(err[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("idle_ready", 32'(ready[d]), 32'd0);
      chk("idle_busy", 32'(busy[d]), 32'd0);
      chk("idle_rdata", rdata[d], 32'd0);
    end

    // Directed word/byte/misaligned sequence on WAIT_CYC=1.
    txn(1, 1'b1, 1'b0, 10'h010, 32'h1234_5678, rd, er);
    txn(1, 1'b0, 1'b0, 10'h010, 32'd0, rd, er);
    chk("word_ld", rd, 32'h1234_5678);
    txn(1, 1'b1, 1'b1, 10'h013, 32'h0000_009A, rd, er);
    txn(1, 1'b0, 1'b0, 10'h010, 32'd0, rd, er);
    chk("after_sb", rd, 32'h9A34_5678);
    txn(1, 1'b0, 1'b1, 10'h013, 32'd0, rd, er);
`ifdef DMEM_LB_SIGNEXT_EN
    chk("lb", rd, 32'hFFFF_FF9A);
`else
    chk("lb", rd, 32'h0000_009A);
`endif
    txn(1, 1'b1, 1'b0, 10'h012, 32'hDEAD_BEEF, rd, er);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    txn(1, 1'b0, 1'b0, 10'h010, 32'd0, rd, er);
    chk("mis_nowrite", rd, 32'h9A34_5678);
    chk("mis_ld_err", 32'(er), 32'd0);

    // Back-to-back on WAIT_CYC=0 and 3.
    for (int d = 0; d < 3; d += 2) begin
      for (int i = 0; i < 4; i++)
        txn(d, 1'b1, 1'b0, 10'h040 + 10'(4 * i), 32'hA000_0000 + 32'(i * 17), rd, er);
      b2b(d, 10'h040);
    end

    // Reset during the wait states of a store on WAIT_CYC=3.
    txn(2, 1'b1, 1'b0, 10'h020, 32'h1111_1111, rd, er);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 1'b0; addr[2] = 10'h020; wdata[2] = 32'hCAFE_F00D;
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy[2]), 32'd0);
    chk("abort_ready", 32'(ready[2]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_noready", 32'(ready[2]), 32'd0);
    end
    txn(2, 1'b0, 1'b0, 10'h020, 32'd0, rd, er);
    chk("abort_nowrite", rd, 32'h1111_1111);

    // Randomized mix against the reference model, every instance.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++)
        txn(d, 1'b1, 1'b0, 10'h100 + 10'(4 * i), $urandom, rd, er);
      for (int i = 0; i < 30; i++)
        txn(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            10'h100 + 10'($urandom_range(0, 31)), $urandom, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
